// File: rtl/int_sequencer_if.sv
// Signal bundle between the interrupt entry sequencer and its surroundings
// (interrupt pin, hazard unit, control unit, PC mux).
interface int_sequencer_if #(
    parameter int ADDR_W = 16
) ();
    logic              int_req;
    logic              pipe_stall;
    logic              ctrl_flush;
    logic              rti_commit;
    logic              int_to_cu;
    logic              fetch_hold;
    logic [ADDR_W-1:0] vec_addr;
    logic              pc_vec_load;
    logic              int_ack;
    logic              in_service;

    modport master (
        output int_req, pipe_stall, ctrl_flush, rti_commit,
        input  int_to_cu, fetch_hold, vec_addr, pc_vec_load, int_ack, in_service
    );

    modport slave (
        input  int_req, pipe_stall, ctrl_flush, rti_commit,
        output int_to_cu, fetch_hold, vec_addr, pc_vec_load, int_ack, in_service
    );
endinterface

// File: rtl/int_sequencer.sv
// Interrupt entry sequencer: captures an interrupt edge, drains the pipeline,
// injects one INT slot into the control unit and vectors the PC to the handler.
module int_sequencer #(
    parameter int          ADDR_W       = 16,
    parameter int unsigned VECTOR_ADDR  = 2,
    parameter int          DRAIN_CYCLES = 3,
    parameter int          VEC_LAT      = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    int_sequencer_if.slave bus
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ALIGN   = 3'd1;
    localparam logic [2:0] ST_DRAIN   = 3'd2;
    localparam logic [2:0] ST_INJECT  = 3'd3;
    localparam logic [2:0] ST_VECTOR  = 3'd4;
    localparam logic [2:0] ST_SERVICE = 3'd5;

    localparam logic [3:0]        DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);
    localparam logic [3:0]        VEC_LOAD   = 4'(VEC_LAT);
    localparam logic [ADDR_W-1:0] VEC_ADDR_C = ADDR_W'(VECTOR_ADDR);

    logic [2:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       pending_q, pending_d;
    logic       req_dly_q, req_dly_d;
    logic       req_edge;
    logic       pending_clr;

    // A new edge always wins over the clear taken when leaving IDLE, so a
    // request arriving in that very cycle is not lost.
    always_comb begin
        req_edge    = bus.int_req & ~req_dly_q;
        pending_clr = (state_q == ST_IDLE) & pending_q;
        pending_d   = req_edge | (pending_q & ~pending_clr);
        req_dly_d   = bus.int_req;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pending_q) begin
                    state_d = ST_ALIGN;
                end
            end
            ST_ALIGN: begin
                if (!bus.pipe_stall && !bus.ctrl_flush) begin
                    state_d = ST_DRAIN;
                    cnt_d   = DRAIN_LOAD;
                end
            end
            ST_DRAIN: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = ST_INJECT;
                end
            end
            ST_INJECT: begin
                if (!bus.pipe_stall) begin
                    state_d = ST_VECTOR;
                    cnt_d   = VEC_LOAD;
                end
            end
            ST_VECTOR: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                if (bus.rti_commit) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // req_dly resets high so a request held through reset is not taken as an edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            pending_q <= 1'b0;
            req_dly_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            req_dly_q <= req_dly_d;
        end
    end

    assign bus.fetch_hold  = (state_q == ST_ALIGN)  || (state_q == ST_DRAIN) ||
                             (state_q == ST_INJECT) || (state_q == ST_VECTOR);
    assign bus.int_to_cu   = (state_q == ST_INJECT);
    assign bus.vec_addr    = (state_q == ST_VECTOR) ? VEC_ADDR_C : '0;
    assign bus.pc_vec_load = (state_q == ST_VECTOR) && (cnt_q == 4'd0);
    assign bus.int_ack     = (state_q == ST_VECTOR) && (cnt_q == 4'd0);
    assign bus.in_service  = (state_q == ST_SERVICE);

endmodule
